// File: rtl/branch_predictor_btb.sv
// Fetch-side direction/target predictor (BTB + 2-bit PHT) trained from resolved EX branches; lookup and mispredict are 0-cycle combinational, training is single-edge, no backpressure.
// Optional global-history (gshare) indexing under `GSHARE_HIST_EN.
module branch_predictor_btb #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    output logic [INDEX_BITS-1:0] pred_ghr,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_taken,
    input  logic [31:0]           ex_target,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    input  logic [INDEX_BITS-1:0] ex_ghr,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic [CNT_W-1:0]      br_count,
    output logic [CNT_W-1:0]      mp_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic                  btb_vld_q [ENTRIES];
    logic [TAG_W-1:0]      btb_tag_q [ENTRIES];
    logic [29:0]           btb_tgt_q [ENTRIES];
    logic [1:0]            pht_q     [ENTRIES];
    logic [CNT_W-1:0]      br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]      mp_cnt_q, mp_cnt_d;

    logic [INDEX_BITS-1:0] if_idx, if_pidx, ex_idx, ex_pidx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit;
    logic                  train, alias_clr, br_mp;
    logic [1:0]            pht_nxt;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[31:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[31:INDEX_BITS+2];

`ifdef GSHARE_HIST_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;

    assign if_pidx  = if_idx ^ ghr_q;
    assign ex_pidx  = ex_idx ^ ex_ghr;
    assign pred_ghr = ghr_q;

    // A mispredicted branch rebuilds history from its own snapshot, dropping wrong-path bits.
    always_comb begin
        ghr_d = ghr_q;
        if (br_mp) begin
            ghr_d = {ex_ghr[INDEX_BITS-2:0], ex_taken};
        end else if (train) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], ex_taken};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic unused_ex_ghr;

    assign if_pidx       = if_idx;
    assign ex_pidx       = ex_idx;
    assign pred_ghr      = '0;
    assign unused_ex_ghr = ^ex_ghr;
`endif

    assign if_hit      = btb_vld_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && pht_q[if_pidx][1];
    assign pred_target = pred_taken ? {btb_tgt_q[if_idx], 2'b00} : (if_pc + 32'd4);

    assign train     = ex_valid && ex_is_branch;
    assign alias_clr = ex_valid && !ex_is_branch && ex_pred_taken;
    assign br_mp     = train && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_target != ex_pred_target)));

    assign mispredict  = br_mp || alias_clr;
    assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + 32'd4);

    always_comb begin
        pht_nxt = pht_q[ex_pidx];
        if (ex_taken && (pht_q[ex_pidx] != 2'b11)) begin
            pht_nxt = pht_q[ex_pidx] + 2'b01;
        end else if (!ex_taken && (pht_q[ex_pidx] != 2'b00)) begin
            pht_nxt = pht_q[ex_pidx] - 2'b01;
        end
    end

    // Taken branches always (re)write the entry: a hit only refreshes the target, a miss evicts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                pht_q[i]     <= 2'b01;
            end
        end else if (train) begin
            pht_q[ex_pidx] <= pht_nxt;
            if (ex_taken) begin
                btb_vld_q[ex_idx] <= 1'b1;
                btb_tag_q[ex_idx] <= ex_tag;
                btb_tgt_q[ex_idx] <= ex_target[31:2];
            end
        end else if (alias_clr) begin
            btb_vld_q[ex_idx] <= 1'b0;
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (train && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispredict && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_count = br_cnt_q;
    assign mp_count = mp_cnt_q;

endmodule
